// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, FSM states,
// alu_op bit indices and IR field positions.
package alu_seq_pkg;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_AND  = 2;
  localparam int unsigned ALU_OR   = 3;
  localparam int unsigned ALU_ROR  = 4;
  localparam int unsigned ALU_ROL  = 5;
  localparam int unsigned ALU_SHR  = 6;
  localparam int unsigned ALU_SHRA = 7;
  localparam int unsigned ALU_SHL  = 8;
  // MUL and DIV share one bit: the datapath's mul/div unit selects by opcode
  localparam int unsigned ALU_MUL  = 9;
  localparam int unsigned ALU_DIV  = 9;
  localparam int unsigned ALU_NEG  = 10;
  localparam int unsigned ALU_NOT  = 11;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, HALT, STEP_WAIT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_BIN, CLS_UN, CLS_MD, CLS_HALT
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    op_class_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  c = CLS_BIN;
      OP_NEG, OP_NOT:                   c = CLS_UN;
      OP_MUL, OP_DIV:                   c = CLS_MD;
      OP_HALT:                          c = CLS_HALT;
      default:                          c = CLS_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [11:0] alu_decode(input logic [4:0] op);
    logic [11:0] v;
    v = '0;
    case (op)
      OP_ADD:  v[ALU_ADD]  = 1'b1;
      OP_SUB:  v[ALU_SUB]  = 1'b1;
      OP_AND:  v[ALU_AND]  = 1'b1;
      OP_OR:   v[ALU_OR]   = 1'b1;
      OP_ROR:  v[ALU_ROR]  = 1'b1;
      OP_ROL:  v[ALU_ROL]  = 1'b1;
      OP_SHR:  v[ALU_SHR]  = 1'b1;
      OP_SHRA: v[ALU_SHRA] = 1'b1;
      OP_SHL:  v[ALU_SHL]  = 1'b1;
      OP_MUL:  v[ALU_MUL]  = 1'b1;
      OP_DIV:  v[ALU_DIV]  = 1'b1;
      OP_NEG:  v[ALU_NEG]  = 1'b1;
      OP_NOT:  v[ALU_NOT]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_reg_sel.sv
// Expands a 4-bit register field plus enable into a one-hot register select.
module reg_sel_decoder #(
  parameter int unsigned NREG = 16
) (
  input  logic [3:0]      field,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (en && (field == i[3:0])) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control unit for register-format ALU instructions.
// Optional single-step mode: define ALU_SEQ_SINGLE_STEP_EN.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned NREG = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_rdy,
  input  logic            step,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out,
  output logic            pc_out,
  output logic            pc_in,
  output logic            inc_pc,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            md_mux_read,
  output logic            ir_in,
  output logic            y_in,
  output logic            zlow_in,
  output logic            zhigh_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            hi_in,
  output logic            lo_in,
  output logic [11:0]     alu_op,
  output logic            run,
  output logic            busy
);

  state_e    state_q, state_d;
  op_class_e op_cls;
  logic [OPW-1:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [3:0] rin_sel, rout_sel;
  logic       rin_en, rout_en, alu_en;
  logic       step_go;
  logic       unused_ir;

  assign opcode    = ir[OP_MSB -: OPW];
  assign ra        = ir[RA_MSB:RA_LSB];
  assign rb        = ir[RB_MSB:RB_LSB];
  assign rc        = ir[RC_MSB:RC_LSB];
  assign op_cls    = classify(opcode);
  assign unused_ir = ^ir[RC_LSB-1:0];

`ifdef ALU_SEQ_SINGLE_STEP_EN
  localparam state_e FINAL_STATE = STEP_WAIT;
  logic armed_q, armed_d;

  // A step=0 cycle re-arms; an advance disarms until step is released.
  always_comb begin
    armed_d = !step || (armed_q && (state_q != STEP_WAIT));
    step_go = step && armed_q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) armed_q <= 1'b0;
    else       armed_q <= armed_d;
  end
`else
  localparam state_e FINAL_STATE = T0;
  logic unused_step;
  assign unused_step = step;
  assign step_go     = 1'b1;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_out      = 1'b0;
    pc_in       = 1'b0;
    inc_pc      = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    md_mux_read = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    zlow_in     = 1'b0;
    zhigh_in    = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rin_sel     = ra;
    rout_sel    = rb;
    alu_en      = 1'b0;

    case (state_q)
      T0: begin
        state_d = T1;
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        zlow_in = 1'b1;
      end
      T1: begin
        md_mux_read = 1'b1;
        mdr_in      = 1'b1;
        // PC reload only on the exit cycle, so a stalled fetch increments once
        if (mem_rdy) begin
          state_d  = T2;
          zlow_out = 1'b1;
          pc_in    = 1'b1;
        end
      end
      T2: begin
        state_d = T3;
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        case (op_cls)
          CLS_BIN: begin
            state_d = T4;
            rout_en = 1'b1;
            y_in    = 1'b1;
          end
          CLS_UN: begin
            state_d = T4;
            rout_en = 1'b1;
            alu_en  = 1'b1;
            zlow_in = 1'b1;
          end
          CLS_MD: begin
            state_d  = T4;
            rout_en  = 1'b1;
            rout_sel = ra;
            y_in     = 1'b1;
          end
          CLS_HALT: state_d = HALT;
          default:  state_d = FINAL_STATE;
        endcase
      end
      T4: begin
        case (op_cls)
          CLS_BIN: begin
            state_d  = T5;
            rout_en  = 1'b1;
            rout_sel = rc;
            alu_en   = 1'b1;
            zlow_in  = 1'b1;
          end
          CLS_UN: begin
            state_d  = FINAL_STATE;
            zlow_out = 1'b1;
            rin_en   = 1'b1;
          end
          CLS_MD: begin
            state_d  = T5;
            rout_en  = 1'b1;
            alu_en   = 1'b1;
            zlow_in  = 1'b1;
            zhigh_in = 1'b1;
          end
          default: state_d = T0;
        endcase
      end
      T5: begin
        case (op_cls)
          CLS_BIN: begin
            state_d  = FINAL_STATE;
            zlow_out = 1'b1;
            rin_en   = 1'b1;
          end
          CLS_MD: begin
            state_d  = T6;
            zlow_out = 1'b1;
            lo_in    = 1'b1;
          end
          default: state_d = T0;
        endcase
      end
      T6: begin
        state_d   = FINAL_STATE;
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      HALT:      state_d = HALT;
      STEP_WAIT: state_d = step_go ? T0 : STEP_WAIT;
      default:   state_d = T0;
    endcase

    // Reset forces state to T0 asynchronously; mask T0's strobes while held
    if (clear) begin
      pc_out      = 1'b0;
      inc_pc      = 1'b0;
      mar_in      = 1'b0;
      zlow_in     = 1'b0;
      pc_in       = 1'b0;
      mdr_in      = 1'b0;
      mdr_out     = 1'b0;
      md_mux_read = 1'b0;
      ir_in       = 1'b0;
      y_in        = 1'b0;
      zhigh_in    = 1'b0;
      zlow_out    = 1'b0;
      zhigh_out   = 1'b0;
      hi_in       = 1'b0;
      lo_in       = 1'b0;
      rin_en      = 1'b0;
      rout_en     = 1'b0;
      alu_en      = 1'b0;
    end
  end

  always_comb begin
    alu_op = alu_en ? alu_decode(opcode[4:0]) : '0;
    run    = (state_q != HALT);
    busy   = (state_q != T0) && (state_q != STEP_WAIT);
  end

  reg_sel_decoder #(.NREG(NREG)) u_rin_dec (
    .field  (rin_sel),
    .en     (rin_en),
    .onehot (r_in)
  );

  reg_sel_decoder #(.NREG(NREG)) u_rout_dec (
    .field  (rout_sel),
    .en     (rout_en),
    .onehot (r_out)
  );

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Moore-style control unit that sequences the datapath through fetch (T0–T2) and execute (T3–T6) for register-format ALU instructions.
- Replaces hand-driven per-state testbench stimulus.
- Reads IR and generates every datapath strobe, including one-hot register in/out selects decoded from IR fields.
- Sits beside the datapath; memory timing is handled by a simple ready handshake during T1.

Parameters:
- OPW, 5, opcode width (IR[31:27])
- NREG, 16, general register count (4-bit fields Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15])

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  reset, asynchronous, active-high
- ir  in  32  current instruction register contents
- mem_rdy  in  1  memory data valid on Mdatain
- step  in  1  single-step advance pulse (see Optional Feature)
- r_in  out  NREG  one-hot register load
- r_out  out  NREG  one-hot register drive
- pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, md_mux_read, ir_in  out  1 each  fetch strobes
- y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in  out  1 each  ALU path strobes
- alu_op  out  12  one-hot {ADD,SUB,AND,OR,ROR,ROL,SHR,SHRA,SHL,MUL,DIV,NEG/NOT pair encoded as bit11=NOT, bit10=NEG}; unused = 0
- run  out  1  high while not halted
- busy  out  1  high in any state other than T0

Behaviour:
- Reset (clear=1, any time, mid-instruction included): state=T0, run=1, all strobes/r_in/r_out/alu_op=0 immediately, not at the next edge.
- Outputs are pure decode of state+ir; each state lasts one clock except T1.
- T0: pc_out, mar_in, inc_pc, zlow_in.
- T1: zlow_out, pc_in asserted only in the cycle that exits T1.
  - md_mux_read and mdr_in are held until mem_rdy=1; exit to T2 on the edge with mem_rdy=1.
  - If mem_rdy is already 1 on entry, T1 lasts one cycle.
  - PC is incremented exactly once per fetch regardless of wait length.
- T2: mdr_out, ir_in. Decode uses ir from T3 onward.
- Binary ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
  - T3: r_out[Rb], y_in.
  - T4: r_out[Rc], alu_op, zlow_in.
  - T5: zlow_out, r_in[Ra]. Then T0.
- Unary ops (neg 10001, not 10010):
  - T3: r_out[Rb], alu_op, zlow_in.
  - T4: zlow_out, r_in[Ra]. Then T0.
- mul 10000 / div 01111:
  - T3: r_out[Ra], y_in.
  - T4: r_out[Rb], alu_op, zlow_in, zhigh_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in. Then T0.
- halt 11011: T3 enters HALT state; run=0; all strobes 0; leaves only via clear.
- nop 11010 and any other unlisted opcode: T3 performs no strobes, then T0.
- r_in and r_out are never both nonzero in the same cycle.
- At most one bus driver (pc_out, mdr_out, zlow_out, zhigh_out, any r_out) is active in any cycle.

Optional Feature:
- Macro: ALU_SEQ_SINGLE_STEP_EN.
- With the macro defined:
  - After the final execute state, enter STEP_WAIT: strobes 0, busy=0.
  - Advance to T0 on a rising edge where step=1; step held high advances only one instruction, since a step=0 cycle must be seen before the next advance.
  - clear overrides.
- Without the macro: step is ignored and the final execute state goes directly to T0.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD…OP_NOT, OP_NOP, OP_HALT);
  - state enum {T0..T6, HALT, STEP_WAIT};
  - alu_op bit-index constants;
  - IR field bit positions.
- One sub-module: reg_sel_decoder, which expands a 4-bit field plus enable into the NREG one-hot vector; instantiate twice (r_in, r_out).

Test Plan:
- ir=0x93380000 (NOT R6,R7), mem_rdy=1:
  - T3 gives r_out=0x0080 with alu_op NOT and zlow_in.
  - T4 gives r_in=0x0040 with zlow_out.
  - Returns to T0 after 5 cycles.
- ir=0x18918000 (ADD R1,R2,R3):
  - T3 r_out=0x0004 with y_in; T4 r_out=0x0008 with ADD; T5 r_in=0x0002.
  - 6 cycles total.
- ir=0x81880000 (MUL R3,R1):
  - T3 r_out=0x0008; T4 r_out=0x0002 with MUL, zlow_in, zhigh_in.
  - T5 lo_in; T6 hi_in; 7 cycles total.
- mem_rdy low for 3 cycles in T1:
  - md_mux_read and mdr_in stay high 4 cycles; pc_in is asserted exactly one cycle.
  - A datapath PC of 0 ends at 1.
- ir=0xD8000000 (halt):
  - run drops after T3 and strobes stay 0 for 20 cycles.
  - Asserting clear restores T0 and run=1 without waiting for a clock edge.
- clear pulse during T4 of ADD: all outputs 0 within the same cycle; next fetch starts at T0 with no r_in pulse.
